// File: rtl/baugh_wooley_multiply.sv
// Baugh-Wooley multiplier with independent per-operand signedness and a
// single output register (one-cycle latency, one product per cycle).
module baugh_wooley_multiply #(
  parameter int unsigned p_width = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   valid_i,
  input  logic [p_width-1:0]     a_i,
  input  logic [p_width-1:0]     b_i,
  input  logic                   a_signed_i,
  input  logic                   b_signed_i,
  output logic                   valid_o,
  output logic [2*p_width-1:0]   product_o
);

  // Extended operand width, product width, and full array width.
  localparam int unsigned EW = p_width + 1;
  localparam int unsigned PW = 2 * p_width;
  localparam int unsigned AW = 2 * EW;

  // Baugh-Wooley correction terms at bit EW and bit AW-1.
  localparam logic [AW-1:0] CORR = (AW'(1) << EW) | (AW'(1) << (AW - 1));

  logic [EW-1:0]         a_ext;
  logic [EW-1:0]         b_ext;
  logic [EW-1:0][AW-1:0] pp;

  logic [PW-1:0] product_d, product_q;
  logic          valid_d, valid_q;

  // The extension bit is set only for a signed operand with its MSB set.
  assign a_ext = {a_signed_i & a_i[p_width-1], a_i};
  assign b_ext = {b_signed_i & b_i[p_width-1], b_i};

  // Partial-product array; terms with exactly one extension bit are inverted.
  for (genvar gi = 0; gi < int'(EW); gi++) begin : g_row
    for (genvar gk = 0; gk < int'(AW); gk++) begin : g_bit
      if ((gk >= gi) && ((gk - gi) < int'(EW))) begin : g_term
        localparam int J = gk - gi;
        if ((gi == int'(EW) - 1) != (J == int'(EW) - 1)) begin : g_inv
          assign pp[gi][gk] = ~(a_ext[gi] & b_ext[J]);
        end else begin : g_and
          assign pp[gi][gk] = a_ext[gi] & b_ext[J];
        end
      end else begin : g_zero
        assign pp[gi][gk] = 1'b0;
      end
    end
  end

  // Ripple-carry accumulation rows, seeded with the correction constant.
  for (genvar r = 0; r < int'(EW); r++) begin : g_add
    logic [AW-1:0] addend;
    logic [AW-1:0] sum;

    if (r == 0) begin : g_seed
      assign addend = CORR;
    end else begin : g_chain
      assign addend = g_add[r-1].sum;
    end

    // One full-adder row: sum = addend + partial-product row r.
    always_comb begin : ripple
      logic c;
      c   = 1'b0;
      sum = '0;
      for (int k = 0; k < int'(AW); k++) begin
        sum[k] = addend[k] ^ pp[r][k] ^ c;
        c      = (addend[k] & pp[r][k]) | (addend[k] & c) | (pp[r][k] & c);
      end
    end
  end

  // Next-state: the exact product fits in the low PW bits of the array sum.
  always_comb begin
    product_d = PW'(g_add[EW-1].sum);
    valid_d   = valid_i;
  end

  // Output register with asynchronous active-high reset.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      product_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      product_q <= product_d;
      valid_q   <= valid_d;
    end
  end

  assign product_o = product_q;
  assign valid_o   = valid_q;

endmodule

// File: tb/tb_baugh_wooley_multiply.sv
// Self-checking bench for baugh_wooley_multiply using an expected-result queue.
module tb_baugh_wooley_multiply;

  localparam int unsigned W  = 4;
  localparam int unsigned PW = 2 * W;

  logic          clk_i;
  logic          reset_i;
  logic          valid_i;
  logic [W-1:0]  a_i;
  logic [W-1:0]  b_i;
  logic          a_signed_i;
  logic          b_signed_i;
  logic          valid_o;
  logic [PW-1:0] product_o;

  int checks;
  int errors;
  logic [PW-1:0] sb_q[$];
  logic [PW-1:0] exp_v;

  baugh_wooley_multiply #(.p_width(W)) dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .valid_i    (valid_i),
    .a_i        (a_i),
    .b_i        (b_i),
    .a_signed_i (a_signed_i),
    .b_signed_i (b_signed_i),
    .valid_o    (valid_o),
    .product_o  (product_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Reference: flag-extended operands multiplied as signed integers.
  function automatic logic [PW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic sa, input logic sb);
    longint av, bv, p;
    av = longint'(a);
    bv = longint'(b);
    if (sa && a[W-1]) av = av - (longint'(1) << W);
    if (sb && b[W-1]) bv = bv - (longint'(1) << W);
    p = av * bv;
    return PW'(p);
  endfunction

  // Drive one operand pair on the falling edge; queue its expected product.
  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sa, input logic sb, input logic v,
                       input logic [PW-1:0] exp_p);
    @(negedge clk_i);
    a_i = a; b_i = b; a_signed_i = sa; b_signed_i = sb; valid_i = v;
    if (v) sb_q.push_back(exp_p);
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (product_o !== '0) begin errors++; $display("FAIL reset_prod got %h want 00", product_o); end
    checks++;
    if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid_o); end
    repeat (2) @(negedge clk_i);
    reset_i = 1'b0;
    drive(4'h3, 4'h5, 1'b0, 1'b0, 1'b1, 8'h0F);
    @(posedge clk_i); #1;
    exp_v = sb_q.pop_front();
    checks++;
    if (product_o !== exp_v || valid_o !== 1'b1) begin
      errors++; $display("FAIL first_after_reset got %h/%b want %h/1", product_o, valid_o, exp_v);
    end
    drive(4'h7, 4'h6, 1'b0, 1'b0, 1'b1, 8'h2A);
    @(posedge clk_i); #1;
    exp_v = sb_q.pop_front();
    checks++;
    if (product_o !== exp_v) begin errors++; $display("FAIL pre_midreset got %h want %h", product_o, exp_v); end
    // Mid-stream asynchronous reset, between clock edges, with valid_i still high.
    #2 reset_i = 1'b1;
    #1;
    checks++;
    if (product_o !== '0 || valid_o !== 1'b0) begin
      errors++; $display("FAIL async_reset got %h/%b want 00/0", product_o, valid_o);
    end
    @(negedge clk_i);
    reset_i = 1'b0;
    sb_q.push_back(8'h2A);
    @(posedge clk_i); #1;
    exp_v = sb_q.pop_front();
    checks++;
    if (product_o !== exp_v || valid_o !== 1'b1) begin
      errors++; $display("FAIL release_reset got %h/%b want %h/1", product_o, valid_o, exp_v);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] ta[8];
    logic [W-1:0] tb[8];
    logic         tsa[8];
    logic         tsb[8];
    logic [PW-1:0] te[8];
    ta = '{4'hF, 4'h0, 4'h8, 4'h8, 4'hF, 4'hF, 4'hF, 4'h8};
    tb = '{4'hF, 4'hF, 4'h8, 4'h7, 4'hF, 4'hF, 4'hF, 4'h8};
    tsa = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tsb = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    te = '{8'hE1, 8'h00, 8'h40, 8'hC8, 8'h01, 8'hF1, 8'hF1, 8'hC0};
    for (int i = 0; i < 8; i++) begin
      drive(ta[i], tb[i], tsa[i], tsb[i], 1'b1, te[i]);
      @(posedge clk_i); #1;
      exp_v = sb_q.pop_front();
      checks++;
      if (product_o !== exp_v || valid_o !== 1'b1) begin
        errors++;
        $display("FAIL directed_%0d a=%h b=%h sa=%b sb=%b got %h/%b want %h/1",
                 i, ta[i], tb[i], tsa[i], tsb[i], product_o, valid_o, exp_v);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a, b;
    logic sa, sb, v;
    for (int i = 0; i < 40; i++) begin
      a  = W'($urandom_range(0, (1 << W) - 1));
      b  = W'($urandom_range(0, (1 << W) - 1));
      sa = 1'($urandom_range(0, 1));
      sb = 1'($urandom_range(0, 1));
      v  = (i % 5 == 3) ? 1'b0 : 1'b1;
      drive(a, b, sa, sb, v, model(a, b, sa, sb));
      @(posedge clk_i); #1;
      checks++;
      if (valid_o !== v) begin
        errors++; $display("FAIL b2b_valid_%0d got %b want %b", i, valid_o, v);
      end
      if (v) begin
        exp_v = sb_q.pop_front();
        checks++;
        if (product_o !== exp_v) begin
          errors++; $display("FAIL b2b_prod_%0d got %h want %h", i, product_o, exp_v);
        end
      end
    end
  endtask

  task automatic test_exhaustive();
    for (int f = 0; f < 4; f++) begin
      for (int a = 0; a < (1 << W); a++) begin
        for (int b = 0; b < (1 << W); b++) begin
          drive(W'(a), W'(b), f[1], f[0], 1'b1, model(W'(a), W'(b), f[1], f[0]));
          @(posedge clk_i); #1;
          exp_v = sb_q.pop_front();
          checks++;
          if (product_o !== exp_v) begin
            errors++;
            $display("FAIL exhaustive a=%h b=%h sa=%b sb=%b got %h want %h",
                     a[W-1:0], b[W-1:0], f[1], f[0], product_o, exp_v);
          end
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset_i = 1'b1;
    valid_i = 1'b0;
    a_i = '0;
    b_i = '0;
    a_signed_i = 1'b0;
    b_signed_i = 1'b0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_exhaustive();
    checks++;
    if (sb_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain got %0d left want 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/baugh_wooley_multiply.md
Name: baugh_wooley_multiply

Overview:
- Parameterised integer multiplier with independent per-operand signedness, using a Baugh-Wooley partial-product array.
- Product is registered once, so latency is one cycle.
- Serves as the shared multiply datapath element for 2's-complement and unsigned operands.
- Output width is 2*p_width, the exact product for every operand/signedness combination.

Parameters:
- p_width, 4, operand width in bits (>= 2); product width is 2*p_width.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- reset_i  input  1  asynchronous, active-high reset.
- valid_i  input  1  operands on a_i/b_i are valid this cycle.
- a_i  input  p_width  multiplicand.
- b_i  input  p_width  multiplier.
- a_signed_i  input  1  1 = a_i is 2's complement; 0 = a_i is unsigned.
- b_signed_i  input  1  1 = b_i is 2's complement; 0 = b_i is unsigned.
- valid_o  output  1  product_o holds the result of an accepted operand pair.
- product_o  output  2*p_width  product of a_i and b_i.

Behaviour:
- Reset (asynchronous, active-high):
  - Asserting reset_i immediately forces product_o = 0 and valid_o = 0, regardless of clock.
  - Outputs hold those values until the first rising edge after reset_i deasserts.
- Arithmetic:
  - Extend each operand to p_width+1 bits. The extension bit is (signed flag AND operand MSB).
  - Treat both extended values as signed (p_width+1)-bit numbers and form their signed product.
  - product_o = the low 2*p_width bits of that product. The result always fits, so truncation loses nothing:
    - unsigned x unsigned: max (2^p_width - 1)^2
    - signed x signed: max 2^(2*p_width-2)
    - mixed: range -2^(p_width-1)*(2^p_width - 1) .. (2^(p_width-1) - 1)*(2^p_width - 1)
- Implementation:
  - Generate the Baugh-Wooley array over the (p_width+1)-bit extended operands.
  - AND partial products; invert partial products that involve exactly one extension bit; add the standard correction constants at bit p_width+1 and bit 2*p_width+1.
  - Sum with ripple/carry-save adder rows built by generate loops.
  - No behavioural "*" operator in synthesisable code.
- Timing:
  - Each rising edge with reset_i low captures product_o <= f(a_i, b_i, a_signed_i, b_signed_i) and valid_o <= valid_i.
  - Latency is exactly 1 cycle; throughput is one product per cycle.
  - product_o updates every cycle regardless of valid_i; consumers qualify it with valid_o.
- Signedness flags may change every cycle and take effect with the operands sampled on the same edge.
- No stall or backpressure; no internal state beyond the output register.

Test Plan:
- Reset: assert reset_i mid-stream with valid_i = 1 -> product_o = 0x00 and valid_o = 0 immediately, without a clock edge; first edge after release gives the registered product of the current inputs.
- Unsigned x unsigned (p_width = 4): a = 0xF, b = 0xF, flags 0/0 -> product_o = 0xE1 one cycle later; a = 0x0, b = 0xF -> 0x00.
- Signed x signed: a = 0x8, b = 0x8, flags 1/1 -> 0x40; a = 0x8 (-8), b = 0x7 -> 0xC8 (-56); a = 0xF, b = 0xF -> 0x01.
- Mixed signedness: a = 0xF signed (-1), b = 0xF unsigned (15) -> 0xF1; swap flags (a unsigned 15, b signed -1) -> 0xF1; a = 0x8 unsigned, b = 0x8 signed -> 0xC0.
- Back-to-back: change operands and flags every cycle with valid_i = 1 -> each product appears exactly one cycle later, valid_o follows valid_i with one-cycle delay.
- Exhaustive: all 4 flag combinations x 16 x 16 operands -> product_o equals the low 8 bits of the signed product of the flag-extended 5-bit operands, with zero mismatches.
